cpu_run_ctrl: RTL and testbench

//  Synthesisable program-load / run / self-check controller for the unified-memory cpu.

---
 rtl/cpu_run_pkg.sv | 23 ++
 rtl/cpu_run_trace_buf.sv | 52 +++++
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the cpu program-load / run / self-check controller.
// The trace depth constants are used only when CPU_RUN_TRACE_EN is defined.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    CHK,
    DONE
  } run_state_e;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_RST_CYCLES = 2;
  localparam int unsigned DEF_MAX_CYCLES = 500;
  localparam int unsigned DEF_CNT_W      = 16;

  localparam int unsigned TRACE_DEPTH    = 16;
  localparam int unsigned TRACE_PTR_W    = 4;

endpackage

// File: rtl/cpu_run_trace_buf.sv
// Circular PC trace buffer for cpu_run_ctrl; built only when CPU_RUN_TRACE_EN is defined.
// A write into a full buffer overwrites the oldest entry; reads pop the oldest.
`ifdef CPU_RUN_TRACE_EN
module cpu_run_trace_buf
  import cpu_run_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_pc,
  output logic              empty
);

  localparam logic [TRACE_PTR_W:0] FULL_CNT = (TRACE_PTR_W+1)'(TRACE_DEPTH);

  logic [ADDR_W-1:0]      entries [TRACE_DEPTH];
  logic [TRACE_PTR_W-1:0] wr_ptr;
  logic [TRACE_PTR_W-1:0] rd_ptr;
  logic [TRACE_PTR_W:0]   count;
  logic                   full;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_pc = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) entries[wr_ptr] <= wr_pc;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + TRACE_PTR_W'(1);
      // when full the oldest entry is dropped, so the read side advances with the write
      if (full) rd_ptr <= rd_ptr + TRACE_PTR_W'(1);
      else      count  <= count + (TRACE_PTR_W+1)'(1);
    end else if (rd_en && !empty) begin
      rd_ptr <= rd_ptr + TRACE_PTR_W'(1);
      count  <= count - (TRACE_PTR_W+1)'(1);
    end
  end

endmodule
`endif

// File: rtl/cpu_run_ctrl.sv
// Program-load / run / self-check controller owning the cpu memory port while the cpu is in reset.
// Optional PC trace buffer and its ports are enabled by defining CPU_RUN_TRACE_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_exp,
  input  logic              chk_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_own,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail
`ifdef CPU_RUN_TRACE_EN
  ,
  input  logic              trace_rd,
  output logic [ADDR_W-1:0] trace_pc,
  output logic              trace_empty,
  input  logic [ADDR_W-1:0] cpu_pc
`endif
);

  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);

  run_state_e        state, state_n;
  logic [ADDR_W-1:0] ld_ptr;
  logic [CNT_W-1:0]  hold_cnt;
  logic              cmp_pend;
  logic              cmp_last;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              start_ok;
  logic              ld_fire;
  logic              chk_fire;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign ld_fire   = ld_valid && ld_ready;
  assign chk_fire  = chk_valid && chk_ready;
  assign mem_wdata = ld_data;
  assign pass      = done && !timeout && (fail_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ld_ready  = 1'b0;
    chk_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_own   = 1'b1;
    cpu_reset = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        mem_addr = ld_ptr;
        mem_we   = ld_valid;
        if (ld_valid && ld_last) state_n = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_n = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        mem_own   = 1'b0;
        if (cpu_halt || cycles == LAST_CYC) state_n = CHK;
      end
      CHK: begin
        // one read in flight at a time keeps mem_rdata paired with its expected word
        chk_ready = !cmp_pend;
        mem_addr  = chk_addr;
        if (cmp_pend && cmp_last) state_n = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      ld_ptr     <= '0;
      hold_cnt   <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
      cmp_pend   <= 1'b0;
      cmp_last   <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
    end else begin
      if (ld_fire) ld_ptr <= ld_ptr + ADDR_W'(1);
      if (state == HOLD) hold_cnt <= hold_cnt + CNT_W'(1);
      if (state == RUN && !cpu_halt) begin
        cycles <= cycles + CNT_W'(1);
        if (cycles == LAST_CYC) timeout <= 1'b1;
      end
      cmp_pend <= chk_fire;
      if (chk_fire) begin
        cmp_last <= chk_last;
        cmp_exp  <= chk_exp;
        cmp_addr <= chk_addr;
      end
      if (cmp_pend && mem_rdata != cmp_exp) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (fail_cnt == '0) first_fail <= cmp_addr;
      end
    end
  end

`ifdef CPU_RUN_TRACE_EN
  cpu_run_trace_buf #(
    .ADDR_W(ADDR_W)
  ) u_trace (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .wr_en (state == RUN),
    .wr_pc (cpu_pc),
    .rd_en (trace_rd && state == DONE),
    .rd_pc (trace_pc),
    .empty (trace_empty)
  );
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: memory and cpu models around the DUT, reference model of the job outcome.
// Define CPU_RUN_TRACE_EN to also exercise the PC trace buffer.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_TRACE_EN
  localparam int MAXC = 32;
`else
  localparam int MAXC = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        chk_valid = 1'b0, chk_last = 1'b0;
  logic [15:0] chk_addr = '0, chk_exp = '0;
  logic        chk_ready;
  logic        mem_we, mem_own, cpu_reset, cpu_halt;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] cycles, fail_cnt, first_fail;
`ifdef CPU_RUN_TRACE_EN
  logic        trace_rd = 1'b0;
  logic [15:0] trace_pc;
  logic        trace_empty;
  logic [15:0] cpu_pc;
`endif

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .ADDR_W(16), .DATA_W(16), .RST_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_exp(chk_exp),
    .chk_last(chk_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_own(mem_own), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycles(cycles), .fail_cnt(fail_cnt), .first_fail(first_fail)
`ifdef CPU_RUN_TRACE_EN
    , .trace_rd(trace_rd), .trace_pc(trace_pc), .trace_empty(trace_empty), .cpu_pc(cpu_pc)
`endif
  );

  // cpu model: counts cycles out of reset, stores count+1 at 0x20 each active cycle,
  // halts once its count reaches halt_at
  logic [15:0] mem [0:255];
  logic [15:0] run_cnt = '0;
  int          halt_at = 1000;
  int          wr_count = 0;

  assign cpu_halt = !cpu_reset && (int'(run_cnt) >= halt_at);
`ifdef CPU_RUN_TRACE_EN
  assign cpu_pc = 16'h0100 + run_cnt;
`endif

  always @(posedge clk) begin
    if (cpu_reset) run_cnt <= '0;
    else           run_cnt <= run_cnt + 16'd1;
  end

  always @(posedge clk) begin
    if (mem_own) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        wr_count <= wr_count + 1;
      end
      mem_rdata <= mem[mem_addr[7:0]];
    end else if (!cpu_halt) begin
      mem[8'h20] <= run_cnt + 16'd1;
    end
  end

  // reference model state
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] ref_mem [0:255];
  logic [15:0] prog[$];
  logic [15:0] ca[$];
  logic [15:0] ce[$];
  logic [15:0] exp_trace[$];
  int          exp_cyc;
  bit          exp_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a job from the rules: budget of MAXC counted cycles, halt wins on the last one.
  task automatic predict(input int h);
    int nrun;
    foreach (prog[i]) ref_mem[i] = prog[i];
    exp_to  = (h >= MAXC);
    exp_cyc = exp_to ? MAXC : h;
    if (exp_cyc > 0) ref_mem[8'h20] = exp_cyc[15:0];
    nrun = exp_to ? MAXC : h + 1;
    exp_trace.delete();
    for (int k = 0; k < nrun; k++) begin
      exp_trace.push_back(16'h0100 + k[15:0]);
      if (exp_trace.size() > 16) void'(exp_trace.pop_front());
    end
  endtask

  task automatic load_prog();
    int k;
    foreach (prog[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == prog.size() - 1);
      k = 0;
      while (ld_ready !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("ld_ready", ld_ready, 1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_run(input int h);
    int k, wr0, exp_fail;
    logic [15:0] exp_ff;
    halt_at = h;
    wr0 = wr_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_prog();
    k = 0;
    while (chk_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_chk", chk_ready, 1);
    foreach (ca[i]) begin
      chk_valid = 1'b1;
      chk_addr  = ca[i];
      chk_exp   = ce[i];
      chk_last  = (i == ca.size() - 1);
      k = 0;
      while (chk_ready !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("chk_ready", chk_ready, 1);
      @(negedge clk);
    end
    chk_valid = 1'b0;
    chk_last  = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    exp_fail = 0;
    exp_ff   = '0;
    foreach (ca[i]) begin
      if (ref_mem[ca[i][7:0]] !== ce[i]) begin
        if (exp_fail == 0) exp_ff = ca[i];
        exp_fail++;
      end
    end
    check("done", done, 1);
    check("busy", busy, 0);
    check("cpu_reset_done", cpu_reset, 1);
    check("mem_own_done", mem_own, 1);
    check("writes", wr_count - wr0, prog.size());
    foreach (prog[i]) check("mem_img", mem[i], prog[i]);
    check("cycles", cycles, exp_cyc);
    check("timeout", timeout, exp_to);
    check("fail_cnt", fail_cnt, exp_fail);
    check("first_fail", first_fail, exp_ff);
    check("pass", pass, (!exp_to && exp_fail == 0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_busy", busy, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_mem_own", mem_own, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_chk_ready", chk_ready, 0);
    check("rst_status", {done, pass, timeout, cycles, fail_cnt, first_fail}, '0);
    reset = 1'b0;
    @(negedge clk);

    // 4-word load, halt after 8 cycles
    prog = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    predict(8);
    ca = '{16'h0020, 16'h0002};
    ce = '{16'h0008, 16'h3333};
    do_run(8);

    // never-halting cpu runs into the budget
    prog = '{16'hA5A5};
    predict(100000);
    ca = '{16'h0020};
    ce = '{MAXC[15:0]};
    do_run(100000);

    // one mismatch at 0x05
    prog = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h000C};
    predict(8);
    ca = '{16'h0020, 16'h0005};
    ce = '{16'h0008, 16'h000D};
    do_run(8);

    // halt on the budget-expiry cycle
    prog = '{16'hBEEF, 16'hCAFE};
    predict(MAXC - 1);
    ca = '{16'h0001};
    ce = '{16'hCAFE};
    do_run(MAXC - 1);

    // reset during RUN, start while busy ignored
    prog = '{16'h7777, 16'h8888};
    halt_at = 100000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_prog();
    ref_mem[0] = 16'h7777;
    ref_mem[1] = 16'h8888;
    n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_run", cpu_reset, 0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ign_cpu_reset", cpu_reset, 0);
    check("start_ign_mem_own", mem_own, 0);
    check("start_ign_ld_ready", ld_ready, 0);
    check("start_ign_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_mem_own", mem_own, 1);
    check("abort_status", {done, timeout, cycles, fail_cnt, first_fail}, '0);
    check("abort_ld_ready", ld_ready, 0);
    @(negedge clk);

    // randomized jobs
    for (int it = 0; it < 8; it++) begin
      int h, nchk;
      logic [15:0] a;
      prog.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
      h = $urandom_range(1, MAXC + 4);
      predict(h);
      ca.delete();
      ce.delete();
      nchk = $urandom_range(1, 4);
      for (int i = 0; i < nchk; i++) begin
        a = ($urandom_range(0, 3) == 0) ? 16'h0020 : 16'($urandom_range(0, n - 1));
        ca.push_back(a);
        ce.push_back(($urandom_range(0, 2) == 0) ? ref_mem[a[7:0]] ^ 16'h0040 : ref_mem[a[7:0]]);
      end
      do_run(h);
    end

`ifdef CPU_RUN_TRACE_EN
    // 20-cycle run, trace returns the last 16 PCs oldest first
    prog = '{16'h0123, 16'h0456, 16'h0789};
    predict(20);
    ca = '{16'h0020};
    ce = '{16'd20};
    do_run(20);
    foreach (exp_trace[i]) begin
      check("trace_nonempty", trace_empty, 0);
      check("trace_pc", trace_pc, exp_trace[i]);
      trace_rd = 1'b1;
      @(negedge clk);
      trace_rd = 1'b0;
    end
    check("trace_empty", trace_empty, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
